simd_proc_gen: RTL

// Parametrised SIMD processing element, next generation of the shared-memory SIMD worker.
// It is configured by a four-instruction setup sequence and then streams a vector job:

---
 rtl/simd_proc_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/simd_proc_gen.sv
// ============================================================================
// Module   : simd_proc_gen
// Brief    : SIMD processing element: 4-instruction setup, then streams A op B -> D
// Revision : 1.0
// ============================================================================
`default_nettype none

module simd_proc_gen #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_valid,
    input  logic [1:0]                 i_instr_op,
    input  logic [ADDR_W-1:0]          i_instr_pld,
    output logic                       o_ack,
    output logic                       o_req_rd,
    input  logic                       i_grant_rd,
    input  logic [LANES*LANE_W-1:0]    i_data,
    output logic                       o_req_wr,
    input  logic                       i_grant_wr,
    output logic [ADDR_W-1:0]          o_addr,
    output logic [LANES*LANE_W-1:0]    o_data,
    output logic [$clog2(LANES):0]     o_wr_size,
    output logic                       o_busy,
    output logic                       o_finish
);

    localparam int                SW          = $clog2(LANES) + 1;
    localparam int                DW          = LANES * LANE_W;
    localparam logic [1:0]        c_LD_A      = 2'b00;
    localparam logic [1:0]        c_LD_B      = 2'b01;
    localparam logic [1:0]        c_LD_D      = 2'b10;
    localparam logic [1:0]        c_INFO      = 2'b11;
    localparam logic [ADDR_W-1:0] c_STRIDE    = ADDR_W'(DW);
    localparam logic [CNT_W-1:0]  c_LANES_CNT = CNT_W'(LANES);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_S_A      = 4'd1,
        ST_S_B      = 4'd2,
        ST_S_D      = 4'd3,
        ST_S_INFO   = 4'd4,
        ST_RD_A     = 4'd5,
        ST_RD_B     = 4'd6,
        ST_WR       = 4'd7,
        ST_FINISHED = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              r_ack;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_d;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_op;
    logic [DW-1:0]     r_reg_a;
    logic [DW-1:0]     r_reg_b;
    logic [CNT_W-1:0]  w_info_cnt;
    logic              w_last;
    logic              w_is_wr;
    logic [SW-1:0]     w_size;

    assign w_info_cnt = i_instr_pld[CNT_W+1:2];
    assign w_last     = (r_count <= c_LANES_CNT);
    assign w_size     = w_last ? SW'(r_count) : SW'(LANES);
    assign w_is_wr    = (r_state == ST_WR);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: if (i_en) w_next = ST_S_A;
            ST_S_A: if (i_valid && i_instr_op == c_LD_A) begin
                w_accept = 1'b1;
                w_next   = ST_S_B;
            end
            ST_S_B: if (i_valid && i_instr_op == c_LD_B) begin
                w_accept = 1'b1;
                w_next   = ST_S_D;
            end
            ST_S_D: if (i_valid && i_instr_op == c_LD_D) begin
                w_accept = 1'b1;
                w_next   = ST_S_INFO;
            end
            ST_S_INFO: if (i_valid && i_instr_op == c_INFO) begin
                w_accept = 1'b1;
                w_next   = (w_info_cnt == '0) ? ST_FINISHED : ST_RD_A;
            end
            ST_RD_A: if (i_grant_rd) w_next = ST_RD_B;
            ST_RD_B: if (i_grant_rd) w_next = ST_WR;
            ST_WR: if (i_grant_wr) w_next = w_last ? ST_FINISHED : ST_RD_A;
            ST_FINISHED: if (i_valid) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_d <= '0;
            r_count  <= '0;
            r_op     <= '0;
            r_reg_a  <= '0;
            r_reg_b  <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_accept;
            if (w_accept) begin
                case (r_state)
                    ST_S_A: r_addr_a <= i_instr_pld;
                    ST_S_B: r_addr_b <= i_instr_pld;
                    ST_S_D: r_addr_d <= i_instr_pld;
                    ST_S_INFO: begin
                        r_count <= w_info_cnt;
                        r_op    <= i_instr_pld[1:0];
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_RD_A && i_grant_rd) r_reg_a <= i_data;
            if (r_state == ST_RD_B && i_grant_rd) r_reg_b <= i_data;
            // All three pointers step together so A, B and D stay beat-aligned.
            if (w_is_wr && i_grant_wr) begin
                r_addr_a <= r_addr_a + c_STRIDE;
                r_addr_b <= r_addr_b + c_STRIDE;
                r_addr_d <= r_addr_d + c_STRIDE;
                if (!w_last) r_count <= r_count - c_LANES_CNT;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        logic [LANE_W-1:0] w_res;

        assign w_a = r_reg_a[gi*LANE_W +: LANE_W];
        assign w_b = r_reg_b[gi*LANE_W +: LANE_W];

        always_comb begin
            case (r_op)
                2'd0:    w_res = w_a + w_b;
                2'd1:    w_res = w_a - w_b;
                2'd2:    w_res = w_a * w_b;
                default: w_res = w_a;
            endcase
        end

        // Tail lanes beyond the valid element count are forced to zero.
        assign o_data[gi*LANE_W +: LANE_W] = (w_is_wr && (w_size > SW'(gi))) ? w_res : '0;
    end

    always_comb begin
        case (r_state)
            ST_RD_B: o_addr = r_addr_b;
            ST_WR:   o_addr = r_addr_d;
            default: o_addr = r_addr_a;
        endcase
    end

    assign o_ack     = r_ack;
    assign o_req_rd  = (r_state == ST_RD_A) || (r_state == ST_RD_B);
    assign o_req_wr  = w_is_wr;
    assign o_wr_size = w_is_wr ? w_size : '0;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_finish  = (r_state == ST_FINISHED);

endmodule

`default_nettype wire
